// File: rtl/byte_dump_pkg.sv
// Shared types for the byte dump sequencer: FSM state encoding.
package byte_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_e;

endpackage

// File: rtl/byte_dump_sequencer.sv
// Walks the whole byte address space once per start request and streams each
// byte out over a valid/ready handshake, pulsing done_out after the last byte.
module byte_dump_sequencer
  import byte_dump_pkg::*;
#(
  parameter int BYTE_ADDR_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_in,
  input  logic                       abort_in,
  output logic [BYTE_ADDR_WIDTH-1:0] byte_addr_out,
  input  logic [7:0]                 byte_data_in,
  output logic [7:0]                 tx_data_out,
  output logic                       tx_valid_out,
  input  logic                       tx_ready_in,
  output logic                       busy_out,
  output logic                       done_out
);

  localparam logic [BYTE_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                     state_q, state_d;
  logic [BYTE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_valid_q, tx_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_in && !abort_in) begin
          addr_d  = '0;
          state_d = ST_FETCH;
        end
      end
      // Memory registers the word at the end of FETCH; the selected byte is
      // stable throughout LOAD.
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        tx_data_d  = byte_data_in;
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready_in) begin
          tx_valid_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + BYTE_ADDR_WIDTH'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a transfer on the same edge: the
    // byte is treated as not sent, so the address is left where it was.
    if (abort_in && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      addr_d     = addr_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = 1'b0;
    end
  end

  assign byte_addr_out = addr_q;
  assign tx_data_out   = tx_data_q;
  assign tx_valid_out  = tx_valid_q;
  assign busy_out      = (state_q != ST_IDLE);
  assign done_out      = (state_q == ST_DONE);

endmodule
